// File: rtl/alt_ddr2_agx2_ex_lfsr8_checker_pkg.sv
// Shared definitions for the 8-bit LFSR read-data checker.
package alt_ddr2_agx2_ex_lfsr8_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_SEED = 32;

    // One LFSR step: shift up, feedback of bit 7 into bits 0, 2, 3 and 4.
    function automatic logic [7:0] nxt(input logic [7:0] d);
        nxt = {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
    endfunction

endpackage

// File: rtl/alt_ddr2_agx2_ex_lfsr8_exp.sv
// Expected-data generator: holds the LFSR value the next beat is compared to.
module alt_ddr2_agx2_ex_lfsr8_exp
    import alt_ddr2_agx2_ex_lfsr8_checker_pkg::*;
#(
    parameter int unsigned SEED = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       reseed,
    input  logic       advance,
    input  logic [7:0] reseed_data,
    output logic [7:0] expected
);

    localparam logic [7:0] SEED8 = 8'(SEED);

    // Load from SEED, reseed from a received beat, or step the sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expected <= SEED8;
        end else if (load) begin
            expected <= SEED8;
        end else if (reseed) begin
            expected <= nxt(reseed_data);
        end else if (advance) begin
            expected <= nxt(expected);
        end
    end

endmodule

// File: rtl/alt_ddr2_agx2_ex_lfsr8_checker.sv
// LFSR read-data checker: run control, beat/error counters, first-error capture.
module alt_ddr2_agx2_ex_lfsr8_checker
    import alt_ddr2_agx2_ex_lfsr8_checker_pkg::*;
#(
    parameter int unsigned SEED  = DEFAULT_SEED,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             sync_mode,
    input  logic [CNT_W-1:0] num_beats,
    input  logic             rdata_valid,
    input  logic [7:0]       rdata,
    output logic [7:0]       expected,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] beat_count,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       first_err_data,
    output logic [7:0]       first_err_exp
);

    state_t           state, state_nxt;
    logic             exp_load, exp_adv, exp_reseed;
    logic             clear, sync_beat, chk_beat, mismatch;
    logic [CNT_W-1:0] beat_inc, err_inc;

    assign beat_inc = (&beat_count) ? beat_count : beat_count + CNT_W'(1);
    assign err_inc  = (&err_count)  ? err_count  : err_count  + CNT_W'(1);
    assign mismatch = chk_beat && (rdata != expected);

    assign busy = (state == ST_SYNC) || (state == ST_CHECK);
    assign done = (state == ST_DONE);
    assign pass = done & ~fail;

    alt_ddr2_agx2_ex_lfsr8_exp #(
        .SEED (SEED)
    ) u_exp (
        .clk         (clk),
        .reset       (reset),
        .load        (exp_load),
        .reseed      (exp_reseed),
        .advance     (exp_adv),
        .reseed_data (rdata),
        .expected    (expected)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle control: enable low beats start, start beats any beat.
    always_comb begin
        state_nxt  = state;
        exp_load   = 1'b0;
        exp_adv    = 1'b0;
        exp_reseed = 1'b0;
        clear      = 1'b0;
        sync_beat  = 1'b0;
        chk_beat   = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
            exp_load  = 1'b1;
            clear     = 1'b1;
        end else if (start) begin
            state_nxt = sync_mode ? ST_SYNC : ST_CHECK;
            exp_load  = 1'b1;
            clear     = 1'b1;
        end else if (rdata_valid) begin
            case (state)
                ST_SYNC: begin
                    exp_reseed = 1'b1;
                    sync_beat  = 1'b1;
                    state_nxt  = (num_beats == CNT_W'(1)) ? ST_DONE : ST_CHECK;
                end
                ST_CHECK: begin
                    exp_adv  = 1'b1;
                    chk_beat = 1'b1;
                    if ((num_beats != '0) && (beat_inc == num_beats)) begin
                        state_nxt = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers: cleared on restart, updated on each sampled beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail           <= 1'b0;
            beat_count     <= '0;
            err_count      <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
        end else if (clear) begin
            fail           <= 1'b0;
            beat_count     <= '0;
            err_count      <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
        end else if (sync_beat) begin
            beat_count <= CNT_W'(1);
        end else if (chk_beat) begin
            beat_count <= beat_inc;
            if (mismatch) begin
                err_count <= err_inc;
                fail      <= 1'b1;
                if (!fail) begin
                    first_err_data <= rdata;
                    first_err_exp  <= expected;
                end
            end
        end
    end

endmodule

// File: tb/tb_alt_ddr2_agx2_ex_lfsr8_checker.sv
// Scoreboard bench for the LFSR read-data checker.
module tb_alt_ddr2_agx2_ex_lfsr8_checker;

    localparam int CW = 16;
    localparam int CMAX = 65535;
    localparam logic [7:0] SEED = 8'h20;

    logic          clk = 1'b0;
    logic          reset, enable, start, sync_mode, rdata_valid;
    logic [CW-1:0] num_beats;
    logic [7:0]    rdata;
    logic [7:0]    expected, first_err_data, first_err_exp;
    logic          busy, done, pass, fail;
    logic [CW-1:0] beat_count, err_count;

    logic       r4, en4, st4, sm4, v4;
    logic [3:0] nb4;
    logic [7:0] d4, exp4, fed4, fee4;
    logic       busy4, done4, pass4, fail4;
    logic [3:0] bc4, ec4;

    always #5 clk = ~clk;

    alt_ddr2_agx2_ex_lfsr8_checker #(.SEED(32), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .sync_mode(sync_mode),
        .num_beats(num_beats), .rdata_valid(rdata_valid), .rdata(rdata),
        .expected(expected), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .beat_count(beat_count), .err_count(err_count),
        .first_err_data(first_err_data), .first_err_exp(first_err_exp)
    );

    alt_ddr2_agx2_ex_lfsr8_checker #(.SEED(32), .CNT_W(4)) dut4 (
        .clk(clk), .reset(r4), .enable(en4), .start(st4), .sync_mode(sm4),
        .num_beats(nb4), .rdata_valid(v4), .rdata(d4),
        .expected(exp4), .busy(busy4), .done(done4), .pass(pass4), .fail(fail4),
        .beat_count(bc4), .err_count(ec4),
        .first_err_data(fed4), .first_err_exp(fee4)
    );

    typedef struct {
        int tag;
        int exp_v, busy_v, done_v, pass_v, fail_v, bc_v, ec_v, fed_v, fee_v;
    } rec_t;

    rec_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the run is a phase plus a position in the sequence from a base.
    localparam int PH_IDLE = 0, PH_SYNC = 1, PH_CHECK = 2, PH_DONE = 3;
    int         ph;
    logic [7:0] base;
    int         pos, m_bc, m_ec;
    bit         m_fail;
    logic [7:0] m_fed, m_fee;

    function automatic logic [7:0] step8(input logic [7:0] d);
        return {d[6:0], d[7]} ^ (d[7] ? 8'h1C : 8'h00);
    endfunction

    function automatic logic [7:0] seq_at(input logic [7:0] b, input int n);
        logic [7:0] x = b;
        for (int i = 0; i < n; i++) x = step8(x);
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic model_restart(input int new_ph);
        ph = new_ph; base = SEED; pos = 0;
        m_bc = 0; m_ec = 0; m_fail = 0; m_fed = 0; m_fee = 0;
    endtask

    // Apply one cycle of inputs, predict the state after the next edge, queue it.
    task automatic drive(input bit en, input bit st, input bit sm, input bit v,
                         input logic [7:0] d, input int nb);
        rec_t r;
        logic [7:0] e;
        enable = en; start = st; sync_mode = sm; rdata_valid = v; rdata = d;
        num_beats = CW'(nb);
        if (!en) model_restart(PH_IDLE);
        else if (st) model_restart(sm ? PH_SYNC : PH_CHECK);
        else if (v && ph == PH_SYNC) begin
            base = step8(d); pos = 0; m_bc = 1;
            ph = (nb == 1) ? PH_DONE : PH_CHECK;
        end else if (v && ph == PH_CHECK) begin
            e = seq_at(base, pos);
            pos++;
            if (m_bc < CMAX) m_bc++;
            if (d != e) begin
                if (!m_fail) begin m_fed = d; m_fee = e; end
                m_fail = 1;
                if (m_ec < CMAX) m_ec++;
            end
            if (nb != 0 && m_bc == nb) ph = PH_DONE;
        end
        r.tag = cyc + 1;
        r.exp_v = int'(seq_at(base, pos));
        r.busy_v = (ph == PH_SYNC || ph == PH_CHECK) ? 1 : 0;
        r.done_v = (ph == PH_DONE) ? 1 : 0;
        r.fail_v = m_fail ? 1 : 0;
        r.pass_v = (r.done_v == 1 && !m_fail) ? 1 : 0;
        r.bc_v = m_bc; r.ec_v = m_ec;
        r.fed_v = int'(m_fed); r.fee_v = int'(m_fee);
        sbq.push_back(r);
        @(posedge clk); #1;
    endtask

    // Monitor: once an edge a queued prediction refers to has passed, compare it.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
                r = sbq.pop_front();
                chk("expected",   32'(expected),       32'(r.exp_v));
                chk("busy",       32'(busy),           32'(r.busy_v));
                chk("done",       32'(done),           32'(r.done_v));
                chk("pass",       32'(pass),           32'(r.pass_v));
                chk("fail",       32'(fail),           32'(r.fail_v));
                chk("beat_count", 32'(beat_count),     32'(r.bc_v));
                chk("err_count",  32'(err_count),      32'(r.ec_v));
                chk("first_err_data", 32'(first_err_data), 32'(r.fed_v));
                chk("first_err_exp",  32'(first_err_exp),  32'(r.fee_v));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_expected"}, 32'(expected), 32'h20);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_pass"}, 32'(pass), 0);
        chk({nm, "_fail"}, 32'(fail), 0);
        chk({nm, "_beat_count"}, 32'(beat_count), 0);
        chk({nm, "_err_count"}, 32'(err_count), 0);
        chk({nm, "_first_err"}, {16'h0, first_err_data, first_err_exp}, 0);
    endtask

    initial begin
        logic [7:0] golden [8];
        logic [7:0] d;
        int nb, n, ev;
        bit sm, v;
        golden = '{8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD};

        reset = 1; enable = 0; start = 0; sync_mode = 0; num_beats = '0;
        rdata_valid = 0; rdata = '0;
        r4 = 1; en4 = 0; st4 = 0; sm4 = 0; v4 = 0; d4 = '0; nb4 = '0;
        model_restart(PH_IDLE);
        @(posedge clk); #1;
        check_reset_outputs("reset");
        reset = 0; r4 = 0;

        // Clean eight-beat run, then beats after done are ignored.
        drive(1, 1, 0, 0, 8'h00, 8);
        for (int i = 0; i < 8; i++) drive(1, 0, 0, 1, golden[i], 8);
        chk("run8_pass", 32'(pass), 1);
        chk("run8_beats", 32'(beat_count), 8);
        drive(1, 0, 0, 1, 8'h55, 8);
        drive(1, 0, 0, 1, 8'hAA, 8);

        // Same run with beat 4 corrupted.
        drive(1, 1, 0, 0, 8'h00, 8);
        for (int i = 0; i < 8; i++) drive(1, 0, 0, 1, (i == 3) ? 8'h1C : golden[i], 8);
        chk("err_run_errs", 32'(err_count), 1);
        chk("err_run_fed", 32'(first_err_data), 32'h1C);
        chk("err_run_fee", 32'(first_err_exp), 32'h1D);

        // Sync mode: first beat seeds, no compare.
        drive(1, 1, 1, 0, 8'h00, 4);
        drive(1, 1, 1, 0, 8'h00, 4);
        for (int i = 2; i < 6; i++) drive(1, 0, 0, 1, golden[i], 4);
        chk("sync_pass", 32'(pass), 1);

        // Gaps between beats, then start together with a beat.
        drive(1, 1, 0, 0, 8'h00, 8);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 1, golden[i], 8);
            repeat (3) drive(1, 0, 0, 0, 8'hFF, 8);
        end
        drive(1, 1, 0, 1, 8'h1D, 8);
        chk("start_beat_discarded", 32'(expected), 32'h20);

        // Enable low mid-run clears everything.
        for (int i = 0; i < 2; i++) drive(1, 0, 0, 1, (i == 0) ? 8'h00 : golden[1], 8);
        drive(0, 0, 0, 1, 8'h80, 8);
        drive(0, 1, 0, 1, 8'h20, 8);

        // Randomized runs.
        for (int r = 0; r < 40; r++) begin
            nb = $urandom_range(0, 10);
            sm = 1'($urandom_range(0, 1));
            drive(1, 1, sm, 0, 8'h00, nb);
            n = (nb == 0) ? 14 : nb + 3;
            for (int k = 0; k < n; k++) begin
                v  = ($urandom_range(0, 3) != 0);
                d  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : seq_at(base, pos);
                ev = $urandom_range(0, 49);
                if (ev == 0) drive(0, 0, sm, v, d, nb);
                else if (ev == 1) drive(1, 1, sm, v, d, nb);
                else drive(1, 0, sm, v, d, nb);
            end
        end

        // Asynchronous reset in the middle of a run.
        drive(1, 1, 0, 0, 8'h00, 8);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, golden[i], 8);
        @(negedge clk); #1;
        reset = 1;
        #1;
        check_reset_outputs("async_reset");
        model_restart(PH_IDLE);
        rdata_valid = 0; start = 0;
        @(posedge clk); #1;
        reset = 0;
        drive(0, 0, 0, 0, 8'h00, 0);
        drive(0, 0, 0, 0, 8'h00, 0);

        // Narrow counters saturate on an unbounded run of wrong beats.
        en4 = 1; st4 = 1; nb4 = 4'd0;
        @(posedge clk); #1;
        st4 = 0; v4 = 1; d4 = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            chk("sat_beat_count", 32'(bc4), 32'((i > 15) ? 15 : i));
            chk("sat_err_count", 32'(ec4), 32'((i > 15) ? 15 : i));
        end
        chk("sat_done", 32'(done4), 0);
        chk("sat_busy", 32'(busy4), 1);
        v4 = 0;

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alt_ddr2_agx2_ex_lfsr8_checker.md
ALT_DDR2_AGX2_EX_LFSR8_CHECKER -- requirements
Module: alt_ddr2_agx2_ex_lfsr8_checker

Interface
REQ-001 Parameter SEED, default 32, 8-bit LFSR start value (SEED[7:0] used).
REQ-002 Parameter CNT_W, default 16, width of the beat and error counters.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  0 forces IDLE and expected data to SEED.
REQ-006 start  in  1  single-cycle pulse; clears results and begins a check run.
REQ-007 sync_mode  in  1  1 seeds expected data from the first received beat instead of SEED.
REQ-008 num_beats  in  CNT_W  beats per run; 0 means unbounded.
REQ-009 rdata_valid  in  1  read-data beat qualifier.
REQ-010 rdata  in  8  read data under test.
REQ-011 expected  out  8  current expected data.
REQ-012 busy  out  1  state is SYNC or CHECK.
REQ-013 done  out  1  run complete (sticky until start, enable low or reset).
REQ-014 pass  out  1  done and no mismatch.
REQ-015 fail  out  1  sticky, at least one mismatch this run.
REQ-016 beat_count  out  CNT_W  beats compared, saturating.
REQ-017 err_count  out  CNT_W  mismatching beats, saturating.
REQ-018 first_err_data / first_err_exp  out  8 each  rdata and expected of the first mismatch.

Function
REQ-019 LFSR advance, nxt(d): d0=d7, d1=d0, d2=d1^d7, d3=d2^d7, d4=d3^d7, d5=d4, d6=d5, d7=d6.
REQ-020 States: IDLE, SYNC, CHECK, DONE, encoded in 2 bits.
REQ-021 IDLE: start with sync_mode=0 -> CHECK, expected=SEED; start with sync_mode=1 -> SYNC.
REQ-022 SYNC: first rdata_valid beat -> expected=nxt(rdata), beat_count=1, no compare, go to CHECK (DONE if num_beats=1).
REQ-023 CHECK: each rdata_valid beat compares rdata to expected, expected=nxt(expected), beat_count+1.
REQ-024 On mismatch: err_count+1 and fail=1; on the first mismatch of a run, capture first_err_data/first_err_exp.
REQ-025 When a beat makes beat_count equal num_beats (num_beats!=0) -> DONE.
REQ-026 DONE: rdata_valid ignored, all outputs held until start or enable low.
REQ-027 All result updates are registered on the edge that samples the beat and are visible the next cycle; no other latency.
REQ-028 rdata_valid in IDLE or DONE is ignored, and expected does not advance.
REQ-029 start in any state restarts the run: counters, fail, done and captures are cleared; a beat in the start cycle is discarded.
REQ-030 enable=0 overrides start: state goes to IDLE, expected=SEED, results are cleared.
REQ-031 Counters saturate at all-ones and do not wrap; a saturated beat_count with num_beats=0 stays in CHECK.
REQ-032 pass = done & ~fail, combinational from registers.

Reset
REQ-033 Reset forces state=IDLE and expected=SEED[7:0], and sets every other output to 0.
REQ-034 Reset asserted mid-run aborts the run; no result survives.

Structure
REQ-035 Shared package holds the state enumeration, the default SEED, and the nxt() function.
REQ-036 One sub-module, alt_ddr2_agx2_ex_lfsr8_exp, is the expected-data generator with load, advance and reseed inputs; control, counters and capture stay in the top module.

Verification
REQ-037 Reset, start with sync_mode=0, num_beats=8, feed 20,40,80,1D,3A,74,E8,CD -> done=1, pass=1, beat_count=8, err_count=0.
REQ-038 Same run with beat 4 sent as 1C -> fail=1, err_count=1, first_err_data=1C, first_err_exp=1D, and beat 5 (3A) still matches.
REQ-039 sync_mode=1, num_beats=4, feed 80,1D,3A,74 -> pass=1 and no compare on the first beat.
REQ-040 Hold rdata_valid low for 3 cycles between beats, then assert start together with rdata_valid mid-run -> gaps do not advance expected, and the start-cycle beat is discarded with expected=20.
REQ-041 Assert reset during CHECK after 3 beats -> all outputs 0 and expected=20, asynchronously, before the next clock edge.
REQ-042 With CNT_W=4 and num_beats=0, send 20 wrong beats -> err_count and beat_count saturate at 15, done stays 0, busy stays 1.
